// File: rtl/mpp_ring_pkg.sv
// ============================================================================
// mpp_ring_pkg : shared widths, saturation constants and FSM encoding for the
//                ring/hover burst detector.           Revision: 1.0
// ============================================================================
`default_nettype none

package mpp_ring_pkg;

  localparam int c_SAMPLE_W = 24;
  localparam int c_LEN_W    = 20;

  localparam logic [c_SAMPLE_W-1:0] c_MAG_MAX     = 24'h7FFFFF;
  localparam logic [c_SAMPLE_W-1:0] c_MAG_MIN_RAW = 24'h800000;
  localparam logic [c_LEN_W-1:0]    c_LEN_MAX     = 20'hFFFFF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  function automatic logic [c_SAMPLE_W-1:0] max_mag(
    input logic [c_SAMPLE_W-1:0] a,
    input logic [c_SAMPLE_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpp_abs_sat.sv
// ============================================================================
// mpp_abs_sat : registered saturating absolute value of a signed sample.
//                                                     Revision: 1.0
// ============================================================================
`default_nettype none

module mpp_abs_sat
  import mpp_ring_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [c_SAMPLE_W-1:0] i_data,
  output logic [c_SAMPLE_W-1:0] o_mag
);

  logic [c_SAMPLE_W-1:0] r_mag;
  logic [c_SAMPLE_W-1:0] w_neg;
  logic [c_SAMPLE_W-1:0] w_abs;

  assign w_neg = ~i_data + 1'b1;

  // The most negative code has no positive twin, so it clamps to full scale.
  always_comb begin
    if (i_data == c_MAG_MIN_RAW) begin
      w_abs = c_MAG_MAX;
    end else if (i_data[c_SAMPLE_W-1]) begin
      w_abs = w_neg;
    end else begin
      w_abs = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mag <= '0;
    end else begin
      r_mag <= w_abs;
    end
  end

  assign o_mag = r_mag;

endmodule

`default_nettype wire

// File: rtl/mpp_ring_hover_detect.sv
// ============================================================================
// mpp_ring_hover_detect : attack/release hover burst detector with burst
//                         length and peak magnitude report. Revision: 1.0
// ============================================================================
`default_nettype none

module mpp_ring_hover_detect
  import mpp_ring_pkg::*;
#(
  parameter logic [c_SAMPLE_W-1:0] THRESH      = 24'd1048576,
  parameter int                    ATTACK_CNT  = 8,
  parameter int                    RELEASE_CNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  detectEnable,
  input  logic [c_SAMPLE_W-1:0] MPPsignal_in,
  output logic                  hoverDetected,
  output logic [c_LEN_W-1:0]    burstLen,
  output logic                  burstLenValid,
  output logic [c_SAMPLE_W-1:0] peakMag
);

  localparam int RUN_MAX = (ATTACK_CNT > RELEASE_CNT) ? ATTACK_CNT : RELEASE_CNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] c_ATT_LAST = RUN_W'(ATTACK_CNT - 1);
  localparam logic [RUN_W-1:0] c_REL_LAST = RUN_W'(RELEASE_CNT - 1);

  logic [c_SAMPLE_W-1:0] r_mag;
  logic [1:0]            r_state;
  logic [RUN_W-1:0]      r_run;
  logic [c_LEN_W-1:0]    r_len;
  logic [c_SAMPLE_W-1:0] r_peak;
  logic [c_LEN_W-1:0]    r_burst_len;
  logic [c_SAMPLE_W-1:0] r_peak_mag;
  logic                  r_valid;

  logic [1:0]            w_state_nxt;
  logic [RUN_W-1:0]      w_run_nxt;
  logic                  w_end;
  logic                  w_above;
  logic                  w_hover;
  logic [c_LEN_W-1:0]    w_len_inc;
  logic [c_SAMPLE_W-1:0] w_peak_max;

  mpp_abs_sat u_abs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (MPPsignal_in),
    .o_mag  (r_mag)
  );

  assign w_above    = (r_mag >= THRESH);
  assign w_hover    = (r_state == ST_ACTIVE) || (r_state == ST_RELEASE);
  assign w_len_inc  = (r_len == c_LEN_MAX) ? r_len : r_len + 1'b1;
  assign w_peak_max = max_mag(r_peak, r_mag);

  // Entering from IDLE already counts as the first qualifying sample.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_end       = 1'b0;
    if (!detectEnable) begin
      w_state_nxt = ST_IDLE;
      w_run_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_above) begin
            if (ATTACK_CNT == 1) begin
              w_state_nxt = ST_ACTIVE;
              w_run_nxt   = '0;
            end else begin
              w_state_nxt = ST_ATTACK;
              w_run_nxt   = RUN_W'(1);
            end
          end
        end
        ST_ATTACK: begin
          if (!w_above) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
          end else if (r_run >= c_ATT_LAST) begin
            w_state_nxt = ST_ACTIVE;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt   = r_run + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!w_above) begin
            if (RELEASE_CNT == 1) begin
              w_state_nxt = ST_IDLE;
              w_run_nxt   = '0;
              w_end       = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_run_nxt   = RUN_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (w_above) begin
            w_state_nxt = ST_ACTIVE;
            w_run_nxt   = '0;
          end else if (r_run >= c_REL_LAST) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
            w_end       = 1'b1;
          end else begin
            w_run_nxt   = r_run + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_len       <= '0;
      r_peak      <= '0;
      r_burst_len <= '0;
      r_peak_mag  <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_valid <= w_end;

      if (!detectEnable || w_end || !w_hover) begin
        r_len <= '0;
      end else begin
        r_len <= w_len_inc;
      end

      // Peak restarts from the sample that opens a new burst out of IDLE.
      if (!detectEnable || w_end) begin
        r_peak <= '0;
      end else if (r_state == ST_IDLE) begin
        r_peak <= w_above ? r_mag : '0;
      end else begin
        r_peak <= w_peak_max;
      end

      if (w_end) begin
        r_burst_len <= w_len_inc;
        r_peak_mag  <= w_peak_max;
      end
    end
  end

  assign hoverDetected = w_hover;
  assign burstLen      = r_burst_len;
  assign burstLenValid = r_valid;
  assign peakMag       = r_peak_mag;

endmodule

`default_nettype wire

// File: tb/tb_mpp_ring_hover_detect.sv
// ============================================================================
// tb_mpp_ring_hover_detect : scoreboard bench for the hover burst detector.
//                                                     Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mpp_ring_hover_detect;

  localparam int EV_RISE  = 0;
  localparam int EV_FALL  = 1;
  localparam int EV_VALID = 2;

  typedef struct {
    int kind;
    int cyc;
    int len;
    int peak;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        detectEnable;
  logic [23:0] sig;

  logic        hov0, val0, hov1, val1;
  logic [19:0] len0, len1;
  logic [23:0] peak0, peak1;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic prev_hover = 1'b0;
  ev_t  exp_q[$];

  mpp_ring_hover_detect #(
    .THRESH(24'd1048576), .ATTACK_CNT(8), .RELEASE_CNT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .detectEnable(detectEnable), .MPPsignal_in(sig),
    .hoverDetected(hov0), .burstLen(len0), .burstLenValid(val0), .peakMag(peak0)
  );

  mpp_ring_hover_detect #(
    .THRESH(24'd1048576), .ATTACK_CNT(1), .RELEASE_CNT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .detectEnable(detectEnable), .MPPsignal_in(sig),
    .hoverDetected(hov1), .burstLen(len1), .burstLenValid(val1), .peakMag(peak1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int len, input int peak);
    ev_t e;
    e.kind = kind; e.cyc = c; e.len = len; e.peak = peak;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input int len, input int peak);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d len %0d peak %0d, expected none",
               kind, cyc, len, peak);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == EV_VALID && (e.len != len || e.peak != peak))) begin
        n_fail++;
        $display("FAIL event: got kind %0d cycle %0d len %0d peak %0d, expected kind %0d cycle %0d len %0d peak %0d",
                 kind, cyc, len, peak, e.kind, e.cyc, e.len, e.peak);
      end
    end
  endtask

  // Monitor: every edge of hoverDetected and every valid pulse is an event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hov0 !== prev_hover) begin
        check_ev(hov0 ? EV_RISE : EV_FALL, 0, 0);
        prev_hover = hov0;
      end
      if (val0 === 1'b1) check_ev(EV_VALID, int'(len0), int'(peak0));
    end
  end

  task automatic drive(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      sig = v[23:0];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    rst_n = 1'b0;
    detectEnable = 1'b1;
    sig = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hover", hov0, 0);
    chk("reset_burstLen", len0, 0);
    chk("reset_valid", val0, 0);
    chk("reset_peak", peak0, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Long quiet stretch, then a 470-sample burst at +2000000.
    drive(0, 1000);
    t0 = cyc;
    push(EV_RISE, t0 + 9, 0, 0);
    push(EV_FALL, t0 + 470 + 17, 0, 0);
    push(EV_VALID, t0 + 470 + 17, 478, 2000000);
    drive(2000000, 470);
    drive(0, 40);
    chk("burstLen_hold_1", len0, 478);

    // Most negative input saturates in the peak report.
    t0 = cyc;
    push(EV_RISE, t0 + 9, 0, 0);
    push(EV_FALL, t0 + 37, 0, 0);
    push(EV_VALID, t0 + 37, 28, 8388607);
    drive(32'hFF800000, 20);
    drive(0, 40);

    // Seven above samples never qualify.
    drive(1500000, 7);
    drive(0, 30);
    chk("burstLen_hold_2", len0, 28);
    chk("peak_hold_2", peak0, 8388607);

    // Single-sample burst on the ATTACK_CNT=1/RELEASE_CNT=1 instance.
    t0 = cyc;
    drive(2000000, 1);
    drive(0, 1);
    chk("cnt1_hover_rise", hov1, 1);
    drive(0, 1);
    chk("cnt1_hover_fall", hov1, 0);
    chk("cnt1_valid", val1, 1);
    chk("cnt1_burstLen", len1, 1);
    chk("cnt1_peak", peak1, 2000000);
    drive(0, 20);

    // One below sample every ten keeps the burst alive; peak from a negative sample.
    t0 = cyc;
    push(EV_RISE, t0 + 9, 0, 0);
    push(EV_FALL, t0 + 99 + 17, 0, 0);
    push(EV_VALID, t0 + 99 + 17, 107, 3000000);
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 9) drive(0, 1);
      else if (i == 55) drive(-3000000, 1);
      else drive(1200000, 1);
    end
    drive(0, 30);

    // THRESH-1 alone is below; exactly THRESH (as -THRESH) is above.
    drive(1048575, 10);
    drive(0, 10);
    t0 = cyc;
    push(EV_RISE, t0 + 9, 0, 0);
    push(EV_FALL, t0 + 27, 0, 0);
    push(EV_VALID, t0 + 27, 18, 1048576);
    drive(-1048576, 10);
    drive(1048575, 30);
    drive(0, 10);

    // Enable drops mid-burst: abort, then a fresh burst after re-enable.
    t0 = cyc;
    push(EV_RISE, t0 + 9, 0, 0);
    push(EV_FALL, t0 + 201, 0, 0);
    drive(1600000, 200);
    detectEnable = 1'b0;
    drive(1100000, 5);
    chk("abort_burstLen_hold", len0, 18);
    chk("abort_peak_hold", peak0, 1048576);
    detectEnable = 1'b1;
    t2 = cyc;
    t3 = t2 + 50;
    push(EV_RISE, t2 + 8, 0, 0);
    push(EV_FALL, t3 + 17, 0, 0);
    push(EV_VALID, t3 + 17, 59, 1100000);
    drive(1100000, 50);
    drive(0, 30);

    // Reset mid-burst clears every output.
    t1 = cyc;
    push(EV_RISE, t1 + 9, 0, 0);
    push(EV_FALL, t1 + 31, 0, 0);
    drive(1300000, 30);
    rst_n = 1'b0;
    drive(0, 2);
    chk("rst_hover", hov0, 0);
    chk("rst_burstLen", len0, 0);
    chk("rst_peak", peak0, 0);
    chk("rst_valid", val0, 0);
    rst_n = 1'b1;
    drive(0, 20);

    chk("events_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mpp_ring_hover_detect.md
MPP_RING_HOVER_DETECT -- requirements
Module: mpp_ring_hover_detect

Interface
REQ-001 Parameter THRESH, default 24'd1048576: magnitude detection threshold, unsigned.
REQ-002 Parameter ATTACK_CNT, default 8: consecutive at-or-above-threshold samples needed to declare hover.
REQ-003 Parameter RELEASE_CNT, default 16: consecutive below-threshold samples needed to end hover.
REQ-004 Port clk, input, 1: single clock, rising edge; one input sample per cycle.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port detectEnable, input, 1: detector enable; low forces the IDLE state.
REQ-007 Port MPPsignal_in, input, 24: signed two's-complement ring/hover signal sample, same format as MPPsignal_out of MPPRingHover.
REQ-008 Port hoverDetected, output, 1: high while a hover burst is declared.
REQ-009 Port burstLen, output, 20: cycles hoverDetected was high in the last completed burst.
REQ-010 Port burstLenValid, output, 1: one-cycle pulse when burstLen and peakMag update.
REQ-011 Port peakMag, output, 24: maximum magnitude seen in the last completed burst.

Function
REQ-012 Stage 1 SHALL register mag = |MPPsignal_in|, with -8388608 saturating to 8388607; all decisions use mag (1-cycle latency).
REQ-013 A sample is "above" when mag >= THRESH, otherwise "below".
REQ-014 FSM states: IDLE, ATTACK, ACTIVE, RELEASE.
REQ-015 IDLE -> ATTACK on an above sample; run counter = 1.
REQ-016 ATTACK: above increments the run counter, below returns to IDLE; the ATTACK_CNT-th consecutive above enters ACTIVE and sets hoverDetected.
REQ-017 Resulting latency: hoverDetected rises ATTACK_CNT+1 cycles after the first above input sample.
REQ-018 ACTIVE -> RELEASE on a below sample; run counter = 1.
REQ-019 RELEASE: above returns to ACTIVE and clears the run counter; the RELEASE_CNT-th consecutive below enters IDLE and clears hoverDetected.
REQ-020 Resulting latency: hoverDetected falls RELEASE_CNT+1 cycles after the first below input sample.
REQ-021 The length counter SHALL count the cycles hoverDetected is high; it saturates at 20'hFFFFF and never wraps.
REQ-022 The peak tracker SHALL hold the maximum mag from ATTACK entry until burst end; it resets when ATTACK is entered from IDLE.
REQ-023 On the RELEASE -> IDLE transition, burstLen and peakMag SHALL load and burstLenValid SHALL pulse for exactly one cycle, coincident with hoverDetected falling.
REQ-024 burstLen and peakMag SHALL hold between valid pulses.
REQ-025 detectEnable low: next state is IDLE, hoverDetected clears, run, length and peak counters clear, and no burstLenValid pulse occurs (aborted burst); burstLen and peakMag hold.
REQ-026 detectEnable rising mid-signal: detection starts fresh from IDLE; mag stage 1 runs regardless of enable.
REQ-027 ATTACK_CNT = 1 or RELEASE_CNT = 1 SHALL work; a single above sample then declares hover.

Reset
REQ-028 rst_n low at a clock edge: state IDLE, mag 0, all counters 0, hoverDetected 0, burstLen 0, burstLenValid 0, peakMag 0.
REQ-029 Reset mid-burst aborts the burst with no burstLenValid pulse; it takes priority over detectEnable and sample data.

Structure
REQ-030 Package mpp_ring_pkg SHALL hold the FSM state encoding, the sample width (24), the length width (20) and the saturation constants.
REQ-031 Sub-module mpp_abs_sat SHALL implement the registered saturating absolute value of REQ-012.
REQ-032 Counters and FSM SHALL live in the top module; no other sub-modules.

Verification
REQ-033 Input 0 for 1000 cycles, then +2000000 for 470 cycles, then 0 -> hoverDetected high 478 cycles; burstLenValid once; burstLen = 478; peakMag = 2000000.
REQ-034 Input -8388608 for 20 cycles, then 0 -> peakMag = 8388607; burstLen = 28.
REQ-035 Input above for 7 cycles, then below -> hoverDetected never rises; no burstLenValid.
REQ-036 Active burst with one below sample every 10 cycles -> hoverDetected stays high continuously; one valid pulse, only after the final 16 below samples.
REQ-037 detectEnable drops at cycle 200 of a burst -> hoverDetected falls the next cycle; no burstLenValid; previous burstLen is held.
REQ-038 Input mag = THRESH exactly is treated as above; mag = THRESH-1 is treated as below; rst_n low mid-burst returns all outputs to 0 on the next edge.
